// File: rtl/hier_icache_ctrl_seq_if.sv
// hier_icache_ctrl_seq_if: peripheral slave bus between the interconnect and the icache command sequencer
interface hier_icache_ctrl_seq_if #(
    parameter int ID_WIDTH = 5
) ();
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic [ID_WIDTH-1:0] id;
    logic                gnt;
    logic                r_valid;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;
    modport master (
        output req, add, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );
    modport slave (
        input  req, add, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/hier_icache_ctrl_seq.sv
// hier_icache_ctrl_seq: L1-then-L2 icache command sequencer; define ICACHE_CTRL_TIMEOUT_EN for the timeout/abort path
module hier_icache_ctrl_seq #(
    parameter int NB_CORES       = 9,
    parameter int NB_CACHE_BANKS = 4,
    parameter int ID_WIDTH       = 5,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    hier_icache_ctrl_seq_if.slave     speriph,
    output logic [NB_CORES-1:0]       l1_req_o,
    input  logic [NB_CORES-1:0]       l1_ack_i,
    output logic [NB_CACHE_BANKS-1:0] l2_req_o,
    input  logic [NB_CACHE_BANKS-1:0] l2_ack_i,
    output logic [1:0]                op_o,
    output logic [31:0]               sel_flush_addr_o,
    output logic                      busy_o,
    output logic                      done_o
);
    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
    state_t state;
    logic [NB_CORES-1:0] l1_mask, l1_left;
    logic [NB_CACHE_BANKS-1:0] l2_mask, l2_lat, l2_left;
    logic [31:0] sel_addr, rdata;
    logic [ID_WIDTH-1:0] r_id;
    logic [TIMEOUT_W-1:0] timeout;
    logic [2:0] sel;
    logic err, l2_go, wr, cmd_go, opc, abort, in_phase, to_l2, unused;
    assign sel = speriph.add[4:2];
    // a new command is held off the bus until the current one has retired
    assign speriph.gnt = speriph.req & ~(busy_o & ~speriph.wen & (sel == 3'd0));
    assign wr = speriph.gnt & ~speriph.wen;
    assign cmd_go = wr & (sel == 3'd0);
    assign speriph.r_id = r_id;
    assign l1_left = l1_req_o & ~l1_ack_i;
    assign l2_left = l2_req_o & ~l2_ack_i;
    assign in_phase = (state == L1) || (state == L2);
    assign to_l2 = l2_go & ~abort;
    assign unused = ^{speriph.be, speriph.add[31:5], speriph.add[1:0]};
    always_comb begin
        rdata = '0;
        opc = 1'b0;
        case (sel)
            3'd1: rdata = 32'(l1_mask);
            3'd2: rdata = 32'(l2_mask);
            3'd3: rdata = sel_addr;
            3'd4: rdata = {30'd0, err, busy_o};
            3'd5: rdata = 32'(timeout);
            3'd6, 3'd7: opc = 1'b1;
            default: ;
        endcase
        if (!speriph.wen) rdata = '0;
    end
`ifdef ICACHE_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;
    // cnt holds the number of phase cycles already elapsed, so the abort fires on the TIMEOUT-th one
    assign abort = in_phase && (timeout != '0) && (cnt + 1'b1 == timeout);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timeout <= '0;
            cnt <= '0;
        end else begin
            if (wr && sel == 3'd5) timeout <= speriph.wdata[TIMEOUT_W-1:0];
            cnt <= (in_phase && !abort && (state == L1 ? |l1_left : |l2_left)) ? cnt + 1'b1 : '0;
        end
    end
`else
    assign timeout = '0;
    assign abort = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            l1_mask <= '1;
            l2_mask <= '1;
            sel_addr <= '0;
            err <= 1'b0;
            speriph.r_valid <= 1'b0;
            speriph.r_opc <= 1'b0;
            speriph.r_rdata <= '0;
            r_id <= '0;
        end else begin
            speriph.r_valid <= speriph.gnt;
            if (speriph.gnt) begin
                speriph.r_opc <= opc;
                speriph.r_rdata <= rdata;
                r_id <= speriph.id;
            end
            if (wr && sel == 3'd1) l1_mask <= speriph.wdata[NB_CORES-1:0];
            if (wr && sel == 3'd2) l2_mask <= speriph.wdata[NB_CACHE_BANKS-1:0];
            if (wr && sel == 3'd3) sel_addr <= speriph.wdata;
            err <= abort | (err & ~(wr && sel == 3'd4 && speriph.wdata[1]));
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            l1_req_o <= '0;
            l2_req_o <= '0;
            l2_lat <= '0;
            l2_go <= 1'b0;
            op_o <= '0;
            sel_flush_addr_o <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (cmd_go) begin
                    op_o <= speriph.wdata[1:0];
                    sel_flush_addr_o <= sel_addr;
                    l2_lat <= l2_mask;
                    l2_go <= speriph.wdata[9] && |l2_mask;
                    busy_o <= 1'b1;
                    if (speriph.wdata[8] && |l1_mask) begin
                        state <= L1;
                        l1_req_o <= l1_mask;
                    end else if (speriph.wdata[9] && |l2_mask) begin
                        state <= L2;
                        l2_req_o <= l2_mask;
                    end else begin
                        state <= DONE;
                        done_o <= 1'b1;
                    end
                end
                L1: begin
                    l1_req_o <= abort ? '0 : l1_left;
                    if (abort || l1_left == '0) begin
                        state <= to_l2 ? L2 : DONE;
                        l2_req_o <= to_l2 ? l2_lat : '0;
                        done_o <= ~to_l2;
                    end
                end
                L2: begin
                    l2_req_o <= abort ? '0 : l2_left;
                    if (abort || l2_left == '0) begin
                        state <= DONE;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hier_icache_ctrl_seq.sv
// tb_hier_icache_ctrl_seq: scoreboarded bench for the icache command sequencer
module tb_hier_icache_ctrl_seq;
    localparam int NC = 9;
    localparam int NB = 4;
    localparam int IDW = 5;
`ifdef ICACHE_CTRL_TIMEOUT_EN
    localparam logic [31:0] TO_RD = 32'd8;
    localparam logic [31:0] TO_ERR = 32'h2;
    localparam int HOLD = 8;
`else
    localparam logic [31:0] TO_RD = 32'd0;
    localparam logic [31:0] TO_ERR = 32'h0;
    localparam int HOLD = 12;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC-1:0] l1_req;
    logic [NC-1:0] l1_ack = '0;
    logic [NB-1:0] l2_req;
    logic [NB-1:0] l2_ack = '0;
    logic [1:0] op;
    logic [31:0] sfa;
    logic busy, done;
    logic prev_gnt = 1'b0;
    logic [IDW+32:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    hier_icache_ctrl_seq_if #(.ID_WIDTH(IDW)) bus_if ();
    hier_icache_ctrl_seq #(.NB_CORES(NC), .NB_CACHE_BANKS(NB), .ID_WIDTH(IDW), .TIMEOUT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .speriph(bus_if),
        .l1_req_o(l1_req), .l1_ack_i(l1_ack), .l2_req_o(l2_req), .l2_ack_i(l2_ack),
        .op_o(op), .sel_flush_addr_o(sfa), .busy_o(busy), .done_o(done)
    );
    always #5 clk = ~clk;
    // response monitor: r_valid must follow grant by one cycle and match the queued expectation
    always @(negedge clk) begin
        logic [IDW+32:0] e;
        if (bus_if.r_valid !== prev_gnt) begin
            checks++;
            errors++;
            $display("FAIL r_valid_timing got %b exp %b", bus_if.r_valid, prev_gnt);
        end else if (prev_gnt) checks++;
        if (bus_if.r_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got id %h opc %b data %h exp none", bus_if.r_id, bus_if.r_opc, bus_if.r_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus_if.r_id, bus_if.r_opc, bus_if.r_rdata} !== e) begin
                    errors++;
                    $display("FAIL resp got id %h opc %b data %h exp id %h opc %b data %h",
                             bus_if.r_id, bus_if.r_opc, bus_if.r_rdata, e[IDW+32:33], e[32], e[31:0]);
                end
            end
        end
        prev_gnt = bus_if.gnt & ~rst;
    end
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input logic eo);
        int n;
        logic [IDW-1:0] i;
        n = 0;
        i = IDW'($urandom);
        bus_if.req = 1'b1;
        bus_if.wen = w;
        bus_if.add = a;
        bus_if.wdata = d;
        bus_if.be = 4'hF;
        bus_if.id = i;
        exp_q.push_back({i, eo, exp});
        @(negedge clk);
        while (bus_if.gnt !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (bus_if.gnt !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL bus_gnt addr %h got 0 exp 1", a);
        end
        @(posedge clk);
        #1;
        bus_if.req = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus_if.req = 1'b0;
        bus_if.wen = 1'b1;
        bus_if.add = '0;
        bus_if.wdata = '0;
        bus_if.be = '0;
        bus_if.id = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({l1_req, l2_req, op, sfa, busy, done, bus_if.r_valid, bus_if.r_opc, bus_if.r_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got l1 %h l2 %h op %h sfa %h busy %b done %b rv %b exp all 0",
                     l1_req, l2_req, op, sfa, busy, done, bus_if.r_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_xfer(1'b1, 32'h04, 0, 32'h1FF, 1'b0);
        bus_xfer(1'b1, 32'h08, 0, 32'hF, 1'b0);
        bus_xfer(1'b1, 32'h0C, 0, 32'h0, 1'b0);
        bus_xfer(1'b1, 32'h10, 0, 32'h0, 1'b0);
        bus_xfer(1'b1, 32'h14, 0, 32'h0, 1'b0);
    endtask
    task automatic test_l1_flush();
        int perm[9] = '{3, 0, 7, 1, 8, 2, 5, 4, 6};
        logic [NC-1:0] exp;
        int dones;
        exp = '1;
        dones = 0;
        bus_xfer(1'b0, 32'h04, 32'h1FF, 0, 1'b0);
        bus_xfer(1'b0, 32'h00, 32'h102, 0, 1'b0);
        for (int j = 0; j < 9; j++) begin
            l1_ack = '0;
            l1_ack[perm[j]] = 1'b1;
            @(negedge clk);
            checks++;
            if (l1_req !== exp || busy !== 1'b1) begin
                errors++;
                $display("FAIL l1_stagger cyc %0d got req %h busy %b exp req %h busy 1", j, l1_req, busy, exp);
            end
            if (done === 1'b1) dones++;
            exp = exp & ~l1_ack;
            @(posedge clk);
            #1;
        end
        l1_ack = '0;
        @(negedge clk);
        checks++;
        if ({l1_req, l2_req, done, busy, op} !== {9'h0, 4'h0, 1'b1, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL l1_done got req %h l2 %h done %b busy %b op %h exp 0 0 1 1 2", l1_req, l2_req, done, busy, op);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00 || dones != 0) begin
            errors++;
            $display("FAIL l1_idle got done %b busy %b early_dones %0d exp 0 0 0", done, busy, dones);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic test_l2_only();
        bus_xfer(1'b0, 32'h04, 32'h0, 0, 1'b0);
        bus_xfer(1'b0, 32'h00, 32'h300, 0, 1'b0);
        @(negedge clk);
        checks++;
        if ({l1_req, l2_req, busy, done, op} !== {9'h0, 4'hF, 1'b1, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL l2_entry got l1 %h l2 %h busy %b done %b op %h exp 0 f 1 0 0", l1_req, l2_req, busy, done, op);
        end
        @(posedge clk);
        #1;
        bus_xfer(1'b1, 32'h10, 0, 32'h1, 1'b0);
        l2_ack = 4'hF;
        @(negedge clk);
        checks++;
        if (l2_req !== 4'hF) begin
            errors++;
            $display("FAIL l2_hold got %h exp f", l2_req);
        end
        @(posedge clk);
        #1;
        l2_ack = '0;
        @(negedge clk);
        checks++;
        if ({l2_req, done} !== {4'h0, 1'b1}) begin
            errors++;
            $display("FAIL l2_all_ack got l2 %h done %b exp 0 1", l2_req, done);
        end
        @(posedge clk);
        #1;
        bus_xfer(1'b0, 32'h04, 32'h1FF, 0, 1'b0);
    endtask
    task automatic test_cmd_busy();
        bus_xfer(1'b0, 32'h00, 32'h100, 0, 1'b0);
        bus_xfer(1'b0, 32'h04, 32'h00F, 0, 1'b0);
        fork
            bus_xfer(1'b0, 32'h00, 32'h102, 0, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (bus_if.gnt !== 1'b0 || l1_req !== 9'h1FF) begin
                        errors++;
                        $display("FAIL busy_hold got gnt %b l1 %h exp 0 1ff", bus_if.gnt, l1_req);
                    end
                    @(posedge clk);
                    #1;
                end
                l1_ack = '1;
                @(negedge clk);
                checks++;
                if (bus_if.gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ack_gnt got %b exp 0", bus_if.gnt);
                end
                @(posedge clk);
                #1;
                l1_ack = '0;
                @(negedge clk);
                checks++;
                if ({bus_if.gnt, done} !== 2'b01) begin
                    errors++;
                    $display("FAIL busy_done got gnt %b done %b exp 0 1", bus_if.gnt, done);
                end
            end
        join
        @(negedge clk);
        checks++;
        if ({l1_req, op, busy} !== {9'h00F, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL second_cmd got l1 %h op %h busy %b exp 00f 2 1", l1_req, op, busy);
        end
        @(posedge clk);
        #1;
        l1_ack = 9'h00F;
        @(posedge clk);
        #1;
        l1_ack = '0;
        @(negedge clk);
        checks++;
        if ({l1_req, done} !== {9'h0, 1'b1}) begin
            errors++;
            $display("FAIL second_done got l1 %h done %b exp 0 1", l1_req, done);
        end
        @(posedge clk);
        #1;
        bus_xfer(1'b0, 32'h04, 32'h1FF, 0, 1'b0);
    endtask
    task automatic test_timeout();
        bus_xfer(1'b0, 32'h14, 32'd8, 0, 1'b0);
        bus_xfer(1'b1, 32'h14, 0, TO_RD, 1'b0);
        bus_xfer(1'b0, 32'h00, 32'h200, 0, 1'b0);
        l2_ack = 4'h7;
        for (int j = 0; j < HOLD; j++) begin
            @(negedge clk);
            checks++;
            if ({l2_req, done} !== {(j == 0) ? 4'hF : 4'h8, 1'b0}) begin
                errors++;
                $display("FAIL stuck_ack cyc %0d got l2 %h done %b exp %h 0", j, l2_req, done, (j == 0) ? 4'hF : 4'h8);
            end
            @(posedge clk);
            #1;
        end
`ifndef ICACHE_CTRL_TIMEOUT_EN
        l2_ack = 4'hF;
        @(negedge clk);
        checks++;
        if (l2_req !== 4'h8) begin
            errors++;
            $display("FAIL late_ack got %h exp 8", l2_req);
        end
        @(posedge clk);
        #1;
`endif
        l2_ack = '0;
        @(negedge clk);
        checks++;
        if ({l2_req, done} !== {4'h0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_end got l2 %h done %b exp 0 1", l2_req, done);
        end
        @(posedge clk);
        #1;
        bus_xfer(1'b1, 32'h10, 0, TO_ERR, 1'b0);
        bus_xfer(1'b0, 32'h10, 32'h2, 0, 1'b0);
        bus_xfer(1'b1, 32'h10, 0, 32'h0, 1'b0);
        bus_xfer(1'b0, 32'h14, 32'h0, 0, 1'b0);
    endtask
    task automatic test_regs();
        bus_xfer(1'b1, 32'h1C, 0, 32'h0, 1'b1);
        bus_xfer(1'b1, 32'h18, 0, 32'h0, 1'b1);
        bus_xfer(1'b0, 32'h1C, 32'hDEAD, 0, 1'b1);
        bus_xfer(1'b0, 32'h04, 32'hFFFF_FFFF, 0, 1'b0);
        bus_xfer(1'b1, 32'h04, 0, 32'h1FF, 1'b0);
        bus_xfer(1'b0, 32'h08, 32'hFFFF_FFFF, 0, 1'b0);
        bus_xfer(1'b1, 32'h08, 0, 32'hF, 1'b0);
        bus_xfer(1'b1, 32'h00, 0, 32'h0, 1'b0);
        bus_xfer(1'b0, 32'h0C, 32'hCAFE_0040, 0, 1'b0);
        bus_xfer(1'b1, 32'h0C, 0, 32'hCAFE_0040, 1'b0);
        bus_xfer(1'b0, 32'h00, 32'h3, 0, 1'b0);
        @(negedge clk);
        checks++;
        if ({op, sfa, done, busy, l1_req, l2_req} !== {2'd3, 32'hCAFE_0040, 1'b1, 1'b1, 9'h0, 4'h0}) begin
            errors++;
            $display("FAIL sel_flush got op %h sfa %h done %b busy %b l1 %h l2 %h exp 3 cafe0040 1 1 0 0",
                     op, sfa, done, busy, l1_req, l2_req);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic test_mid_reset();
        int dones;
        dones = 0;
        bus_xfer(1'b0, 32'h04, 32'h0AA, 0, 1'b0);
        bus_xfer(1'b0, 32'h08, 32'h3, 0, 1'b0);
        bus_xfer(1'b0, 32'h00, 32'h302, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (l1_req !== 9'h0AA) begin
            errors++;
            $display("FAIL pre_reset_req got %h exp 0aa", l1_req);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({l1_req, l2_req, op, sfa, busy, done, bus_if.r_valid} !== '0) begin
            errors++;
            $display("FAIL mid_reset got l1 %h l2 %h op %h sfa %h busy %b done %b exp all 0", l1_req, l2_req, op, sfa, busy, done);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (done !== 1'b0 || l1_req !== '0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL post_reset_quiet got %0d active cycles exp 0", dones);
        end
        @(posedge clk);
        #1;
        bus_xfer(1'b1, 32'h04, 0, 32'h1FF, 1'b0);
        bus_xfer(1'b1, 32'h08, 0, 32'hF, 1'b0);
        bus_xfer(1'b1, 32'h10, 0, 32'h0, 1'b0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_l1_flush();
        test_l2_only();
        test_cmd_busy();
        test_timeout();
        test_regs();
        test_mid_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL resp_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
